// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose
//    Raster timing generator for a VGA-style display. Two free-running
//    counters (h_cnt for the pixel within a line, v_cnt for the line within
//    a frame) walk the full raster including porches and sync. Every output
//    is a registered decode of the counter state, so all outputs carry the
//    same one-pixel latency and stay mutually aligned.
//
// Parameters
//    H_ACTIVE, H_FP, H_SYNC, H_BP : visible pixels, front porch, sync width,
//                                   back porch (pixels)
//    V_ACTIVE, V_FP, V_SYNC, V_BP : visible lines, front porch, sync width,
//                                   back porch (lines)
//    The totals H_TOTAL and V_TOTAL must each fit in 10 bits.
//
// Ports
//    clk          in   system clock
//    rst_n        in   synchronous active-low reset
//    pix_ce       in   pixel clock enable (tie high when clk is the pixel clock)
//    hsync        out  horizontal sync, active-low
//    vsync        out  vertical sync, active-low
//    display_on   out  high inside the visible area
//    screen_hpos  out  current column (10 bits)
//    screen_vpos  out  current line (10 bits)
//    line_start   out  one-pixel pulse at column 0 of every line
//    frame_start  out  one-pixel pulse at column 0 of line 0
//    frame_count  out  frames completed since reset (8 bits)
//
// Build option
//    VGA_FRAME_COUNT_EN : when defined, frame_count is a live modulo-256
//                         frame counter; when undefined it is tied to 0
//                         and no counter logic exists.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_ce,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] screen_hpos,
   output logic [9:0] screen_vpos,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   // Raster geometry, pre-cast to the counter width so every compare below
   // is a plain 10-bit compare.
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   // ------------------------------------------------------------------
   // Raster counters
   // ------------------------------------------------------------------
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       h_last;
   logic       v_last;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   // Reset wins over pix_ce so a reset pulse always abandons the current
   // frame, even when it lands on a cycle with no pixel enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_ce) begin
         if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + 10'd1;
            end
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Decode of the current counter state. These become the outputs on the
   // next pix_ce edge, which gives the fixed one-pixel output latency.
   // ------------------------------------------------------------------
   logic hsync_next;
   logic vsync_next;
   logic display_on_next;
   logic line_start_next;
   logic frame_start_next;

   always_comb begin
      hsync_next       = 1'b1;
      vsync_next       = 1'b1;
      display_on_next  = 1'b0;
      line_start_next  = 1'b0;
      frame_start_next = 1'b0;

      if ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) begin
         hsync_next = 1'b0;
      end
      if ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) begin
         vsync_next = 1'b0;
      end
      display_on_next  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      line_start_next  = (h_cnt == 10'd0);
      frame_start_next = (h_cnt == 10'd0) && (v_cnt == 10'd0);
   end

   // ------------------------------------------------------------------
   // Output registers. They only load on pix_ce edges, so a pulse seen on
   // the outputs persists across any pix_ce=0 cycles that follow it.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         display_on  <= 1'b0;
         screen_hpos <= '0;
         screen_vpos <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_ce) begin
         hsync       <= hsync_next;
         vsync       <= vsync_next;
         display_on  <= display_on_next;
         screen_hpos <= h_cnt;
         screen_vpos <= v_cnt;
         line_start  <= line_start_next;
         frame_start <= frame_start_next;
      end
   end

   // ------------------------------------------------------------------
   // Frame counter
   // ------------------------------------------------------------------
`ifdef VGA_FRAME_COUNT_EN
   // frame_cnt counts completed frames at the counter level; it steps on
   // the same edge that wraps the raster back to (0,0). Its value is then
   // pushed through the output register together with the (0,0) decode, so
   // frame_count changes on exactly the output cycle where frame_start is
   // high.
   logic [7:0] frame_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (pix_ce && h_last && v_last) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_count <= '0;
      end else if (pix_ce) begin
         frame_count <= frame_cnt;
      end
   end
`else
   assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Self-checking bench for vga_timing_gen. The DUT is built with a small
// raster (16 x 10 including porches) so that hundreds of whole frames fit
// in a short run. A position model derives every expected output from the
// number of pixel enables seen since reset and is compared against the DUT
// on every clock; directed phases add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int HA = 8;
   localparam int HF = 2;
   localparam int HS = 3;
   localparam int HB = 3;
   localparam int VA = 6;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 1;
   localparam int HT = HA + HF + HS + HB;   // 16
   localparam int VT = VA + VF + VS + VB;   // 10
   localparam int FT = HT * VT;             // 160

`ifdef VGA_FRAME_COUNT_EN
   localparam int FC_EN = 1;
`else
   localparam int FC_EN = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pix_ce = 1'b0;
   logic       hsync;
   logic       vsync;
   logic       display_on;
   logic [9:0] screen_hpos;
   logic [9:0] screen_vpos;
   logic       line_start;
   logic       frame_start;
   logic [7:0] frame_count;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_ce     (pix_ce),
      .hsync      (hsync),
      .vsync      (vsync),
      .display_on (display_on),
      .screen_hpos(screen_hpos),
      .screen_vpos(screen_vpos),
      .line_start (line_start),
      .frame_start(frame_start),
      .frame_count(frame_count)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 40) begin
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Model: n = pixel enables accepted since reset. Output position is
   // pixel index n-1 of the raster; n=0 means reset values are shown.
   // ------------------------------------------------------------------
   int unsigned n = 0;
   bit check_en = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         n <= 0;
      end else if (pix_ce) begin
         n <= n + 1;
      end
   end

   int m_p, m_h, m_v, m_f;
   int e_hs, e_vs, e_de, e_ls, e_fs, e_fc;

   always @(negedge clk) begin
      if (check_en) begin
         if (n == 0) begin
            m_h = 0; m_v = 0;
            e_hs = 1; e_vs = 1; e_de = 0; e_ls = 0; e_fs = 0; e_fc = 0;
         end else begin
            m_p = int'(n) - 1;
            m_h = m_p % HT;
            m_v = (m_p / HT) % VT;
            m_f = m_p / FT;
            e_hs = (m_h >= HA + HF && m_h < HA + HF + HS) ? 0 : 1;
            e_vs = (m_v >= VA + VF && m_v < VA + VF + VS) ? 0 : 1;
            e_de = (m_h < HA && m_v < VA) ? 1 : 0;
            e_ls = (m_h == 0) ? 1 : 0;
            e_fs = (m_h == 0 && m_v == 0) ? 1 : 0;
            e_fc = (FC_EN != 0) ? (m_f % 256) : 0;
         end
         chk("model_hpos", int'(screen_hpos), m_h);
         chk("model_vpos", int'(screen_vpos), m_v);
         chk("model_hsync", int'(hsync), e_hs);
         chk("model_vsync", int'(vsync), e_vs);
         chk("model_display_on", int'(display_on), e_de);
         chk("model_line_start", int'(line_start), e_ls);
         chk("model_frame_start", int'(frame_start), e_fs);
         chk("model_frame_count", int'(frame_count), e_fc);
      end
   end

   // ------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ------------------------------------------------------------------
   initial begin
      int hs_low, hs_first, de_cnt, de_max, vs_low, fs_cnt;
      int cyc, first_rise, second_rise, k;
      bit prev_ls, found;

      // Reset with pixel enable active
      rst_n = 1'b0;
      pix_ce = 1'b1;
      repeat (3) @(negedge clk);
      check_en = 1'b1;
      chk("reset_hsync", int'(hsync), 1);
      chk("reset_vsync", int'(vsync), 1);
      chk("reset_display_on", int'(display_on), 0);
      chk("reset_hpos", int'(screen_hpos), 0);
      chk("reset_line_start", int'(line_start), 0);
      chk("reset_frame_start", int'(frame_start), 0);
      $display("phase reset: outputs at reset values checked");

      // First output cycle after release shows the (0,0) decode
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_hpos", int'(screen_hpos), 0);
      chk("first_vpos", int'(screen_vpos), 0);
      chk("first_display_on", int'(display_on), 1);
      chk("first_line_start", int'(line_start), 1);
      chk("first_frame_start", int'(frame_start), 1);
      chk("first_hsync", int'(hsync), 1);
      chk("first_vsync", int'(vsync), 1);
      $display("phase first_output: (0,0) decode checked");

      // One visible line: hsync low for 3 pixels from column 10,
      // display_on for columns 0..7
      hs_low = 0; hs_first = -1; de_cnt = 0; de_max = -1;
      for (int i = 0; i < HT; i++) begin
         if (!hsync) begin
            if (hs_first < 0) hs_first = int'(screen_hpos);
            hs_low++;
         end
         if (display_on) begin
            de_cnt++;
            de_max = int'(screen_hpos);
         end
         @(negedge clk);
      end
      chk("line_hsync_low_cycles", hs_low, 3);
      chk("line_hsync_first_hpos", hs_first, 10);
      chk("line_display_cycles", de_cnt, 8);
      chk("line_display_last_hpos", de_max, 7);
      $display("phase line: hsync low=%0d from hpos=%0d, display=%0d", hs_low, hs_first, de_cnt);

      // One frame period: vsync low for 2 lines (32 cycles), one frame_start
      vs_low = 0; fs_cnt = 0;
      for (int i = 0; i < FT; i++) begin
         if (!vsync) vs_low++;
         if (frame_start) fs_cnt++;
         @(negedge clk);
      end
      chk("frame_vsync_low_cycles", vs_low, 32);
      chk("frame_start_per_frame", fs_cnt, 1);
      $display("phase frame: vsync low=%0d, frame_start count=%0d", vs_low, fs_cnt);

      // Alternating pixel enable: line period doubles to 32 clocks
      prev_ls = line_start; cyc = 0; first_rise = -1; second_rise = -1;
      for (int i = 0; i < 300; i++) begin
         pix_ce = ~pix_ce;
         @(negedge clk);
         cyc++;
         if (line_start && !prev_ls) begin
            if (first_rise < 0) begin
               first_rise = cyc;
            end else begin
               second_rise = cyc;
               break;
            end
         end
         prev_ls = line_start;
      end
      chk("toggle_line_period", second_rise - first_rise, 32);
      pix_ce = 1'b1;
      $display("phase toggle: line period=%0d clocks", second_rise - first_rise);

      // One-cycle reset mid-frame inside an hsync pulse, with pix_ce low
      found = 1'b0;
      for (int i = 0; i < 4 * FT; i++) begin
         if (screen_hpos == 10'd12 && screen_vpos == 10'd4) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("midframe_position_found", int'(found), 1);
      rst_n = 1'b0;
      pix_ce = 1'b0;
      @(negedge clk);
      chk("midreset_hsync", int'(hsync), 1);
      chk("midreset_hpos", int'(screen_hpos), 0);
      chk("midreset_vpos", int'(screen_vpos), 0);
      chk("midreset_display_on", int'(display_on), 0);
      rst_n = 1'b1;
      pix_ce = 1'b1;
      @(negedge clk);
      chk("restart_hpos", int'(screen_hpos), 0);
      chk("restart_vpos", int'(screen_vpos), 0);
      chk("restart_frame_start", int'(frame_start), 1);
      chk("restart_hsync", int'(hsync), 1);
      $display("phase midframe_reset: restart from (0,0) checked");

      // Frame counter across 257 completed frames
      k = 0;
      chk("fc_frame0", int'(frame_count), 0);
      for (int i = 0; i < 258 * FT; i++) begin
         @(negedge clk);
         if (frame_start) begin
            k++;
            if (k == 1)   chk("fc_frame1", int'(frame_count), FC_EN * 1);
            if (k == 255) chk("fc_frame255", int'(frame_count), FC_EN * 255);
            if (k == 256) chk("fc_frame256_wrap", int'(frame_count), 0);
            if (k == 257) begin
               chk("fc_frame257", int'(frame_count), FC_EN * 1);
               break;
            end
         end
      end
      chk("fc_frame_starts_seen", k, 257);
      $display("phase frame_count: %0d frame starts observed", k);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical porch and sync widths in lines.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst_n, input, 1; reset is synchronous, active-low; clock clk.
REQ-007 SHALL have port pix_ce, input, 1, pixel clock enable; tie high when clk is the 25 MHz pixel clock.
REQ-008 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-009 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-010 SHALL have port display_on, output, 1, high inside the visible area.
REQ-011 SHALL have port screen_hpos, output, 10, current column, consumed by the frame-buffer controller as counter_H.
REQ-012 SHALL have port screen_vpos, output, 10, current line, consumed as counter_V.
REQ-013 SHALL have port line_start, output, 1, one-pixel pulse at column 0 of every line.
REQ-014 SHALL have port frame_start, output, 1, one-pixel pulse at column 0 of line 0.
REQ-015 SHALL have port frame_count, output, 8, frames completed since reset.

Function
REQ-016 SHALL keep internal counters h_cnt over 0..H_TOTAL-1 and v_cnt over 0..V_TOTAL-1, where H_TOTAL is the sum of the four H parameters (800) and V_TOTAL is the sum of the four V parameters (525).
REQ-017 SHALL advance h_cnt by 1 on each clk edge with pix_ce=1; SHALL hold all state when pix_ce=0.
REQ-018 SHALL wrap h_cnt at H_TOTAL-1 to 0 and on that same edge increment v_cnt.
REQ-019 SHALL wrap v_cnt to 0 when both h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
REQ-020 SHALL register all outputs from the counter state with exactly 1 pix_ce cycle latency; all outputs SHALL be mutually aligned.
REQ-021 SHALL drive screen_hpos=h_cnt and screen_vpos=v_cnt, zero-extended to 10 bits; both counters fit 10 bits.
REQ-022 SHALL assert hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is 656..751.
REQ-023 SHALL assert vsync low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is 490..491.
REQ-024 SHALL set display_on=1 if and only if h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-025 SHALL set line_start=1 if and only if h_cnt=0, and frame_start=1 if and only if h_cnt=0 and v_cnt=0; each pulse lasts one pix_ce cycle.
REQ-026 SHALL NOT change outputs on pix_ce=0 cycles; a pulse persists until the next pix_ce=1 edge.

Reset
REQ-027 SHALL, when rst_n=0 at a clk edge, regardless of pix_ce, set h_cnt=0, v_cnt=0 and frame_count=0.
REQ-028 SHALL, during reset, drive hsync=1, vsync=1, display_on=0, screen_hpos=0, screen_vpos=0, line_start=0 and frame_start=0.
REQ-029 SHALL, on the first pix_ce=1 edge after reset release, present h=0 and v=0 decode at the outputs: display_on=1, line_start=1, frame_start=1.
REQ-030 SHALL, on reset mid-line or mid-frame, abandon the current frame immediately with no partial sync pulse carried over.

Configuration
REQ-031 SHALL, with macro VGA_FRAME_COUNT_EN defined, increment frame_count modulo 256 on each v_cnt wrap edge; frame_count shall be aligned with frame_start.
REQ-032 SHALL, without VGA_FRAME_COUNT_EN, keep the frame_count port present and tie it to constant 0 with no counter logic.

Verification
REQ-033 Reset, then pix_ce=1: the first output cycle has hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1, hsync=1, vsync=1.
REQ-034 Free-run 800 cycles: hsync is low for exactly 96 cycles starting at hpos=656, and display_on is high for hpos 0..639 only.
REQ-035 Free-run 420000 cycles: vsync is low for lines 490..491, which is 1600 cycles, and frame_start is seen once per 420000 cycles.
REQ-036 Toggle pix_ce 1/0 alternately: outputs change only on pix_ce=1 edges, and the line period is 1600 clk cycles.
REQ-037 Assert rst_n=0 for 1 cycle at vpos=300, hpos=700: the next outputs are the reset values, then decode restarts from (0,0).
REQ-038 With VGA_FRAME_COUNT_EN, run 257 frames: frame_count goes 0..255 and then wraps to 0 then 1; without the macro, frame_count stays 0.
